mc_mem_responder: RTL

- Memory-side responder for the multi-cycle CPU control unit's memory requests (mem_read / mem_write, with the address already selected by the IorD mux).
- Backs a word-addressed RAM and services one request at a time.
- Inserts a configurable number of wait states and signals completion with a one-cycle ready pulse.
- Rejects malformed requests with an error pulse, so the control FSM can be extended to stall on ready.

---
 rtl/mc_mem_responder.sv | 99 +++++++++
 1 files changed

// File: rtl/mc_mem_responder.sv
// rtl/mc_mem_responder.sv - word-addressed RAM responder for multi-cycle CPU memory requests
// One request in flight; wait states, ready pulse, error pulse for malformed requests.
module mc_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;
  logic [31:0]       mem_q [DEPTH];

  logic req;
  logic valid;
  logic commit;

  assign req    = mem_read | mem_write;
  assign valid  = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            waddr_q <= addr[ADDR_W-1:2];
            wdata_q <= wdata;
            we_q    <= mem_write;
            if (valid) begin
              cnt_q   <= 4'(WAIT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end else begin
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_RESP;
            if (!we_q) rdata_q <= mem_q[waddr_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // A request still held after the ready cycle must drop before re-accept.
        S_RESP:    state_q <= req ? S_RELEASE : S_IDLE;
        S_RELEASE: if (!req) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q) mem_q[waddr_q] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
